// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell evaluated per clock, LSB first,
// with a carry flip-flop closing the loop and a one-cycle done pulse on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] partial;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_c;

  // Full-adder cell fed by the LSBs of the operand shifters and the carry FF.
  assign cell_s = op_a[0] ^ op_b[0] ^ carry;
  assign cell_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of the others, which is what makes the shift chain work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      partial <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          carry   <= cell_c;
          op_a    <= op_a >> 1;
          op_b    <= op_b >> 1;
          partial <= {cell_s, partial[WIDTH-1:1]};
          cnt     <= cnt + CNT_W'(1);
          // Last bit: publish the result; sum/cout hold it until the next completion.
          if (cnt == LAST) begin
            sum   <= {cell_s, partial[WIDTH-1:1]};
            cout  <= cell_c;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases, randomized
// operations against an arithmetic reference, busy-start rejection, async reset.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int TMO   = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, WIDTH+1 bits wide.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // One operation with a one-cycle start; inputs are scrambled after acceptance.
  // lat: posedges after acceptance until done is seen; busy_n: busy samples from
  // acceptance through the cycle after done; done_after: done one cycle later;
  // sum_mid/cout_mid: outputs sampled mid-operation.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                        output int lat, output int busy_n, output logic done_after,
                        output logic [WIDTH-1:0] sum_mid, output logic cout_mid);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 0; busy_n = 0; sum_mid = 'x; cout_mid = 1'bx;
    if (busy) busy_n++;
    while (!done && lat < TMO) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (busy) busy_n++;
      if (lat == 4) begin sum_mid = sum; cout_mid = cout; end
    end
    @(posedge clk);
    @(negedge clk);
    if (busy) busy_n++;
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({sum, cout, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] xs [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [WIDTH-1:0] ys [3] = '{8'h01, 8'h01, 8'hFF};
    logic             cs [3] = '{1'b0, 1'b0, 1'b1};
    int lat, busy_n;
    logic da, cm;
    logic [WIDTH-1:0] sm;
    logic [WIDTH:0] exp;
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], ys[i], cs[i], lat, busy_n, da, sm, cm);
      exp = model(xs[i], ys[i], cs[i]);
      tests_run++;
      if (lat !== WIDTH) begin
        tests_failed++;
        $display("FAIL directed%0d_latency: got %0d edges, want %0d", i, lat, WIDTH);
      end
      tests_run++;
      if ({cout, sum} !== exp) begin
        tests_failed++;
        $display("FAIL directed%0d_result: got cout=%b sum=%h, want cout=%b sum=%h",
                 i, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      tests_run++;
      if (busy_n !== WIDTH + 1 || da !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed%0d_busy_done: got busy_cycles=%0d done_next=%b, want %0d 0",
                 i, busy_n, da, WIDTH + 1);
      end
    end
  endtask

  task automatic test_random;
    int lat, busy_n;
    logic da, cm;
    logic [WIDTH-1:0] sm, x, y;
    logic c;
    logic [WIDTH:0] exp, prev;
    prev = {cout, sum};
    for (int i = 0; i < 20; i++) begin
      x = WIDTH'($urandom); y = WIDTH'($urandom); c = 1'($urandom);
      if (i == 0) begin x = '1; y = '0; c = 1'b1; end
      run_op(x, y, c, lat, busy_n, da, sm, cm);
      exp = model(x, y, c);
      tests_run++;
      if ({cout, sum} !== exp || lat !== WIDTH) begin
        tests_failed++;
        $display("FAIL random%0d: %h+%h+%b got cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
                 i, x, y, c, cout, sum, lat, exp[WIDTH], exp[WIDTH-1:0], WIDTH);
      end
      tests_run++;
      if ({cm, sm} !== prev) begin
        tests_failed++;
        $display("FAIL random%0d_hold: mid-op got cout=%b sum=%h, want previous cout=%b sum=%h",
                 i, cm, sm, prev[WIDTH], prev[WIDTH-1:0]);
      end
      prev = exp;
    end
  endtask

  task automatic test_busy_ignore;
    int dones, first_at, lat, busy_n;
    logic da, cm;
    logic [WIDTH-1:0] sm, sum_at;
    logic cout_at;
    logic [WIDTH:0] exp;
    @(negedge clk);
    a = 8'h21; b = 8'h43; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; first_at = -1; sum_at = '0; cout_at = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = (e == 2);
      if (e == 2) begin a = 8'hF0; b = 8'h0F; cin = 1'b0; end
      if (done) begin
        dones++;
        if (first_at < 0) begin first_at = e; sum_at = sum; cout_at = cout; end
      end
    end
    start = 1'b0;
    tests_run++;
    if (dones !== 1 || first_at !== WIDTH) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: got %0d done pulses first at edge %0d, want 1 at %0d",
               dones, first_at, WIDTH);
    end
    exp = model(8'h21, 8'h43, 1'b1);
    tests_run++;
    if ({cout_at, sum_at} !== exp) begin
      tests_failed++;
      $display("FAIL busy_original_result: got cout=%b sum=%h, want cout=%b sum=%h",
               cout_at, sum_at, exp[WIDTH], exp[WIDTH-1:0]);
    end
    run_op(8'h5A, 8'hA5, 1'b1, lat, busy_n, da, sm, cm);
    exp = model(8'h5A, 8'hA5, 1'b1);
    tests_run++;
    if ({cout, sum} !== exp || lat !== WIDTH) begin
      tests_failed++;
      $display("FAIL after_ignore_op: got cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
               cout, sum, lat, exp[WIDTH], exp[WIDTH-1:0], WIDTH);
    end
  endtask

  task automatic test_mid_reset;
    int dones, busies;
    @(negedge clk);
    a = 8'h7E; b = 8'h13; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({sum, cout, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0; busies = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    tests_run++;
    if (dones !== 0 || busies !== 0 || sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_abort: got done=%0d busy=%0d sum=%h after reset, want 0 0 00", dones, busies, sum);
    end
  endtask

  task automatic test_back_to_back;
    int at [2];
    logic [WIDTH-1:0] s_at [2];
    logic c_at [2];
    int n;
    logic [WIDTH:0] e0, e1;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h80; b = 8'h80;
    n = 0; at[0] = -1; at[1] = -1; s_at[0] = '0; s_at[1] = '0; c_at[0] = 0; c_at[1] = 0;
    for (int e = 1; e <= 2 * TMO && n < 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin at[n] = e; s_at[n] = sum; c_at[n] = cout; n++; end
    end
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);
    e0 = model(8'h12, 8'h34, 1'b0);
    e1 = model(8'h80, 8'h80, 1'b0);
    tests_run++;
    if (n !== 2 || at[1] - at[0] !== WIDTH + 2 || at[0] !== WIDTH) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d dones at edges %0d,%0d, want 2 at %0d,%0d",
               n, at[0], at[1], WIDTH, 2 * WIDTH + 2);
    end
    tests_run++;
    if ({c_at[0], s_at[0]} !== e0 || {c_at[1], s_at[1]} !== e1) begin
      tests_failed++;
      $display("FAIL b2b_results: got %b/%h %b/%h, want %b/%h %b/%h",
               c_at[0], s_at[0], c_at[1], s_at[1], e0[WIDTH], e0[WIDTH-1:0], e1[WIDTH], e1[WIDTH-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
